// File: rtl/enc8to3_event_pkg.sv
// enc8to3_event_pkg: shared widths and vector types for the event encoder.
package enc8to3_event_pkg;
    localparam int ENC_W = 3;
    localparam int LINES = 8;
    typedef logic [LINES-1:0] line_t;
    typedef logic [ENC_W-1:0] idx_t;
endpackage

// File: rtl/pri_enc8to3.sv
// pri_enc8to3: combinational lowest-index-first priority encoder with one-hot grant.
module pri_enc8to3
    import enc8to3_event_pkg::*;
(
    input  logic [LINES-1:0] cand,
    output logic [ENC_W-1:0] idx,
    output logic             any,
    output logic [LINES-1:0] grant
);
    always_comb begin
        idx = '0;
        for (int i = LINES - 1; i >= 0; i--)
            if (cand[i]) idx = idx_t'(i);
    end
    // Two's-complement trick isolates the lowest set bit.
    assign grant = cand & (~cand + line_t'(1));
    assign any   = |cand;
endmodule

// File: rtl/enc8to3_event.sv
// enc8to3_event: synchronizes eight request lines and delivers each rising edge
// as a 3-bit index on a valid/ready interface.
module enc8to3_event
    import enc8to3_event_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LINES-1:0] in,
    input  logic             en,
    input  logic             clr,
    output logic [ENC_W-1:0] out,
    output logic             valid,
    input  logic             ready,
    output logic [LINES-1:0] pending,
    output logic             overflow
);
    line_t sync_q [SYNC_STAGES];
    line_t sync_d [SYNC_STAGES];
    line_t prev_q, prev_d, pending_q, pending_d;
    line_t s, rise, cand, grant_oh, grant;
    idx_t  out_q, out_d, idx;
    logic  valid_q, valid_d, overflow_q, overflow_d, any, free;

    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
        if (g == 0) begin : g_first
            assign sync_d[g] = in;
        end else begin : g_next
            assign sync_d[g] = sync_q[g-1];
        end
    end

    pri_enc8to3 u_pri (
        .cand  (cand),
        .idx   (idx),
        .any   (any),
        .grant (grant_oh)
    );

    always_comb begin
        s          = sync_q[SYNC_STAGES-1];
        prev_d     = s;
        rise       = s & ~prev_q & {LINES{en}};
        cand       = pending_q | rise;
        free       = !valid_q || ready;
        grant      = free ? grant_oh : '0;
        // A fresh edge on the bit just granted from pending is a new event and stays pending.
        pending_d  = clr ? '0 : (cand & ~grant) | (rise & pending_q & grant);
        overflow_d = !clr && (overflow_q || |(rise & pending_q & ~grant));
        valid_d    = !clr && (free ? any : valid_q);
        out_d      = (free && any && !clr) ? idx : out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q     <= '0;
            pending_q  <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign out      = out_q;
    assign valid    = valid_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_enc8to3_event.sv
// tb_enc8to3_event: directed stimulus with a per-cycle behavioural model check.
module tb_enc8to3_event;
    localparam int SS = 2;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1, clr = 1'b0, ready = 1'b1;
    logic [7:0] in = 8'h00;
    logic [2:0] out;
    logic       valid, overflow;
    logic [7:0] pending;
    int         checks = 0, errors = 0;

    enc8to3_event #(.SYNC_STAGES(SS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .en       (en),
        .clr      (clr),
        .out      (out),
        .valid    (valid),
        .ready    (ready),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Behavioural model: delay line, edge detect, lowest-bit search per the event rules.
    logic [7:0] m_sync [SS];
    logic [7:0] m_prev, m_pend;
    logic [2:0] m_out;
    logic       m_valid, m_ovf;

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] s, rise, cand, np;
        logic       free, ov, gr;
        int         gi;
        if (!rst_n) begin
            for (int k = 0; k < SS; k++) m_sync[k] <= 8'h00;
            m_prev  <= 8'h00;
            m_pend  <= 8'h00;
            m_out   <= 3'd0;
            m_valid <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            s    = m_sync[SS-1];
            rise = s & ~m_prev & {8{en}};
            cand = m_pend | rise;
            free = !m_valid || ready;
            gi   = -1;
            for (int i = 0; i < 8; i++) if (cand[i] && gi < 0) gi = i;
            ov = m_ovf;
            for (int i = 0; i < 8; i++) begin
                gr    = free && (gi == i);
                np[i] = gr ? (rise[i] && m_pend[i]) : cand[i];
                if (rise[i] && m_pend[i] && !gr) ov = 1'b1;
            end
            for (int k = SS - 1; k > 0; k--) m_sync[k] <= m_sync[k-1];
            m_sync[0] <= in;
            m_prev    <= s;
            if (clr) begin
                m_pend  <= 8'h00;
                m_ovf   <= 1'b0;
                m_valid <= 1'b0;
            end else begin
                m_pend <= np;
                m_ovf  <= ov;
                if (free) begin
                    m_valid <= (gi >= 0);
                    if (gi >= 0) m_out <= 3'(gi);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_out", {5'd0, out}, {5'd0, m_out});
        chk("model_valid", {7'd0, valid}, {7'd0, m_valid});
        chk("model_pending", pending, m_pend);
        chk("model_overflow", {7'd0, overflow}, {7'd0, m_ovf});
    end

    initial begin
        // Reset with all lines high, release with lines low.
        in = 8'hFF;
        tick(3);
        chk("rst_valid", {7'd0, valid}, 8'h00);
        chk("rst_out", {5'd0, out}, 8'h00);
        chk("rst_pending", pending, 8'h00);
        chk("rst_overflow", {7'd0, overflow}, 8'h00);
        rst_n = 1'b1;
        in = 8'h00;
        tick(6);
        chk("post_rst_valid", {7'd0, valid}, 8'h00);

        // Single edge on line 2: valid on the third edge after first sample.
        in = 8'h04;
        tick(2);
        chk("single_early", {7'd0, valid}, 8'h00);
        tick(1);
        chk("single_valid", {7'd0, valid}, 8'h01);
        chk("single_out", {5'd0, out}, 8'h02);
        chk("single_pend", pending, 8'h00);
        tick(1);
        chk("single_drop", {7'd0, valid}, 8'h00);
        in = 8'h00;
        tick(4);

        // Simultaneous edges on lines 1, 4, 7.
        in = 8'h92;
        tick(3);
        chk("sim_out1", {5'd0, out}, 8'h01);
        chk("sim_pend1", pending, 8'h90);
        tick(1);
        chk("sim_out4", {5'd0, out}, 8'h04);
        tick(1);
        chk("sim_out7", {5'd0, out}, 8'h07);
        chk("sim_valid7", {7'd0, valid}, 8'h01);
        tick(1);
        chk("sim_end_valid", {7'd0, valid}, 8'h00);
        chk("sim_end_pend", pending, 8'h00);
        in = 8'h00;
        tick(4);

        // Backpressure on lines 3 and 6.
        ready = 1'b0;
        in = 8'h48;
        tick(3);
        repeat (10) begin
            chk("bp_out", {5'd0, out}, 8'h03);
            chk("bp_valid", {7'd0, valid}, 8'h01);
            chk("bp_pend", pending, 8'h40);
            tick(1);
        end
        ready = 1'b1;
        tick(1);
        chk("bp_out6", {5'd0, out}, 8'h06);
        chk("bp_pend0", pending, 8'h00);
        tick(1);
        chk("bp_done", {7'd0, valid}, 8'h00);
        in = 8'h00;
        tick(4);

        // Overflow: line 0 occupies output, line 5 pulsed twice.
        ready = 1'b0;
        in = 8'h01;
        tick(3);
        chk("ov_hold_out", {5'd0, out}, 8'h00);
        chk("ov_hold_valid", {7'd0, valid}, 8'h01);
        in = 8'h21; tick(1);
        in = 8'h01; tick(1);
        in = 8'h21; tick(1);
        in = 8'h01; tick(4);
        chk("ov_pend", pending, 8'h20);
        chk("ov_flag", {7'd0, overflow}, 8'h01);
        ready = 1'b1;
        tick(1);
        chk("ov_out5", {5'd0, out}, 8'h05);
        chk("ov_valid5", {7'd0, valid}, 8'h01);
        tick(1);
        chk("ov_once", {7'd0, valid}, 8'h00);
        chk("ov_sticky", {7'd0, overflow}, 8'h01);

        // Clear with a held event and pending work.
        ready = 1'b0;
        in = 8'h0D;
        tick(3);
        chk("clr_pre_out", {5'd0, out}, 8'h02);
        chk("clr_pre_pend", pending, 8'h08);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_valid", {7'd0, valid}, 8'h00);
        chk("clr_pend", pending, 8'h00);
        chk("clr_ovf", {7'd0, overflow}, 8'h00);
        in = 8'h00;
        ready = 1'b1;
        tick(4);

        // Enable gating: no event while disabled, none on re-enable.
        en = 1'b0;
        in = 8'h02;
        tick(5);
        chk("en_off_valid", {7'd0, valid}, 8'h00);
        chk("en_off_pend", pending, 8'h00);
        en = 1'b1;
        tick(5);
        chk("en_on_valid", {7'd0, valid}, 8'h00);
        in = 8'h00;
        tick(4);

        // Mid-operation reset during a held valid.
        ready = 1'b0;
        in = 8'h04;
        tick(3);
        chk("mr_valid", {7'd0, valid}, 8'h01);
        chk("mr_out", {5'd0, out}, 8'h02);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_async_valid", {7'd0, valid}, 8'h00);
        tick(1);
        rst_n = 1'b1;
        ready = 1'b1;
        tick(2);
        chk("mr_wait", {7'd0, valid}, 8'h00);
        tick(1);
        chk("mr_event", {7'd0, valid}, 8'h01);
        chk("mr_event_out", {5'd0, out}, 8'h02);
        tick(1);
        chk("mr_once", {7'd0, valid}, 8'h00);
        tick(4);
        chk("mr_quiet", pending, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/enc8to3_event.md
# enc8to3_event

Event encoder: the counterpart to the 3-to-8 decoders. It watches eight asynchronous request lines and turns each rising edge into a 3-bit index. Indices are delivered one at a time on a valid/ready output interface. The block sits between raw request or button inputs and any consumer that wants a binary line number, such as an interrupt controller or a status register.

## Interface
Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per input line; legal values are 1 to 3.

Ports:
- clk  input  1  sole clock; all flops on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  8  asynchronous request lines; bit i is line i.
- en  input  1  capture enable; 0 means new edges are ignored.
- clr  input  1  synchronous clear of pending events, overflow and valid.
- out  output  3  encoded index of the delivered event.
- valid  output  1  out holds an event.
- ready  input  1  consumer accepts the event.
- pending  output  8  events captured but not yet issued.
- overflow  output  1  sticky flag: an event was merged into one already pending.

## Operation
- Each bit of `in` passes through SYNC_STAGES flops, giving `s`. A register `prev` holds the previous value of `s`.
- rise = s & ~prev & {8{en}}.
- `prev` tracks `s` regardless of `en`. Re-enabling therefore never produces a spurious edge.
- cand = pending | rise.
- Issue slot is free when !valid || ready.
- If the slot is free and cand != 0:
  - out <= index of the lowest set bit of cand (bit 0 has highest priority).
  - valid <= 1.
  - That bit is excluded from the pending update for this cycle.
- If the slot is free and cand == 0: valid <= 0, and out keeps its old value.
- If the slot is not free (valid && !ready): out and valid hold.
- pending <= cand & ~grant_onehot.
  - Exception: if a rise falls on the very bit being granted from pending, that bit stays set. The new edge counts as a new event.
- overflow <= 1 when rise[i] && pending[i] && !(bit i granted this cycle). The two events merge into one pending bit.
- overflow stays set until clr or reset.
- clr = 1 forces, at the next edge, pending = 0, overflow = 0 and valid = 0. The sync and `prev` flops are unaffected. rise in the clr cycle is discarded.
- Reset values: sync flops 0, prev 0, pending 0, out 3'd0, valid 0, overflow 0.
- A line that is high when reset is released produces exactly one event once it is synchronized.
- Asserting rst_n low mid-operation clears everything immediately, including an un-accepted valid.

## Timing
- A transfer occurs on a clock edge with valid && ready.
- Latency is measured from the first clock edge that samples `in` high. With the issue slot free, valid rises after SYNC_STAGES+1 edges: 3 edges at the default setting.
- Throughput: one event per cycle while ready = 1.
- Under backpressure, out and valid are stable. They change only on the edge after an accepted transfer.
- Pulses on `in` shorter than one clk period may be lost; that is by design.
- Falling edges generate nothing.
- pending and overflow are registered outputs, updated on the same edge as out and valid.

## Structure
- Shared package holds:
  - ENC_W = 3 and LINES = 8;
  - the typedefs for the line vector (8 bits) and the index (3 bits).
- Sub-module pri_enc8to3: purely combinational.
  - Input: cand[7:0].
  - Outputs: idx[2:0], any, and grant one-hot [7:0].
  - Lowest index has priority.
  - Instantiated once.
- Top level holds:
  - the synchronizer (a generate loop over SYNC_STAGES);
  - prev, pending and overflow;
  - the output register.

## Test plan
- Reset: hold rst_n = 0 with in = 8'hFF, then release with in = 8'h00, ready = 1. Expect all outputs 0 during reset and no events after release.
- Single edge: with SYNC_STAGES = 2 and ready = 1, drive in from 0 to 8'h04. Expect valid = 1 for exactly one cycle, 3 edges after the first sampling edge, with out = 3'd2. pending stays 0.
- Simultaneous edges: drive in from 0 to 8'h92 with ready = 1. Expect out = 1, 4, 7 on three consecutive valid cycles, then valid = 0 and pending = 0.
- Backpressure: with ready = 0, create events on lines 3 and 6. Expect valid held with out = 3 stable for 10 cycles and pending = 8'h40. Then ready = 1 gives out = 3, then out = 6.
- Overflow and clear:
  - With ready = 0 and line 0 occupying the output, pulse line 5 twice. Expect pending[5] = 1 and overflow = 1. After ready rises, exactly one out = 5 is delivered.
  - Pulse clr. Expect overflow = 0, pending = 0 and valid = 0.
- Enable and mid-operation reset:
  - With en = 0, an edge on line 1 produces no event. Raising en while line 1 is still high produces no event.
  - With en = 1, start an event on line 2, then assert rst_n during valid. Expect valid = 0 immediately; after release, line 2 (still high) produces one event.
